// File: rtl/calc_pkg.sv
// Shared calculator definitions: token codes, 4x4 keypad legend and scanner FSM states.
// Latency: none; constants, types and one pure lookup function.
// Backpressure: not applicable.
package calc_pkg;

  localparam logic [3:0] TOK_ADD = 4'hA;
  localparam logic [3:0] TOK_SUB = 4'hB;
  localparam logic [3:0] TOK_MUL = 4'hC;
  localparam logic [3:0] TOK_DIV = 4'hD;
  localparam logic [3:0] TOK_EQ  = 4'hE;
  localparam logic [3:0] TOK_CLR = 4'hF;

  // Nibble {row,col} holds the token for that key.
  // Row 0: 1 2 3 A, row 1: 4 5 6 B, row 2: 7 8 9 C, row 3: F 0 E D.
  localparam logic [63:0] KEY_MAP = 64'hDE0F_C987_B654_A321;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} scan_state_t;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous level inputs.
// Latency: 2 clk cycles from input change to dout.
// Backpressure: none; continuously samples.
module sync_2ff #(
  parameter int              W       = 4,
  parameter logic [W-1:0]    RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop gives it a cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      dout <= RST_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_token_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, one token+strobe per press.
// Latency: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a press on the active column.
// Backpressure: none; strobe is a single-cycle pulse the consumer must take.
// Optional auto-repeat while held is compiled in with KEYPAD_AUTOREPEAT_EN.
module keypad_token_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] token,
  output logic       strobe,
  output logic       key_down
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       rs;
  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [1:0]       row_idx, row_idx_nxt;
  logic [3:0]       token_nxt;
  logic             strobe_nxt, key_down_nxt;
  logic             hit_vld;
  logic [1:0]       hit_row;
  logic [3:0]       row_pat;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [31:0]      rep_cnt, rep_cnt_nxt;
  logic             rep_first, rep_first_nxt;
  logic [31:0]      rep_last;
`endif

  sync_2ff #(.W(4), .RST_VAL(4'b1111)) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rows_n),
    .dout  (rs)
  );

  assign cols_n  = ~(4'b0001 << col_idx);
  assign row_pat = ~(4'b0001 << row_idx);

  // Decode a single low row; zero or several low rows (ghosting) is no hit.
  always_comb begin
    hit_vld = 1'b1;
    hit_row = 2'd0;
    case (rs)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit_vld = 1'b0;
    endcase
  end

  // Next-state and output decisions; counters only increment below their limit.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    col_idx_nxt  = col_idx;
    row_idx_nxt  = row_idx;
    token_nxt    = token;
    strobe_nxt   = 1'b0;
    key_down_nxt = key_down;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nxt   = rep_cnt;
    rep_first_nxt = rep_first;
    rep_last      = rep_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);
`endif
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (hit_vld) begin
            row_idx_nxt = hit_row;
            state_nxt   = DEBOUNCE;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs == row_pat) begin
          if (cnt == DB_LAST) begin
            // Outputs are registered on entry so token is valid while strobe is high.
            state_nxt    = EMIT;
            cnt_nxt      = '0;
            token_nxt    = key_code(row_idx, col_idx);
            strobe_nxt   = 1'b1;
            key_down_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
        end
      end
      EMIT: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_nxt   = 32'd1;
        rep_first_nxt = 1'b1;
`endif
      end
      default: begin
        if (rs == 4'b1111) begin
          if (cnt == DB_LAST) begin
            state_nxt    = SCAN;
            cnt_nxt      = '0;
            key_down_nxt = 1'b0;
            col_idx_nxt  = col_idx + 2'd1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          cnt_nxt = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat timer ignores release glitches; it only stops when release is accepted.
        if (state_nxt == HOLD) begin
          if (rs != 4'b1111 && rep_cnt >= rep_last && token != TOK_EQ && token != TOK_CLR) begin
            strobe_nxt    = 1'b1;
            rep_cnt_nxt   = 32'd0;
            rep_first_nxt = 1'b0;
          end else if (rep_cnt != '1) begin
            rep_cnt_nxt = rep_cnt + 32'd1;
          end
        end
`endif
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      cnt      <= '0;
      col_idx  <= 2'd0;
      row_idx  <= 2'd0;
      token    <= 4'h0;
      strobe   <= 1'b0;
      key_down <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= 32'd0;
      rep_first <= 1'b1;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      col_idx  <= col_idx_nxt;
      row_idx  <= row_idx_nxt;
      token    <= token_nxt;
      strobe   <= strobe_nxt;
      key_down <= key_down_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= rep_cnt_nxt;
      rep_first <= rep_first_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_token_scanner.sv
module tb_keypad_token_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [3:0]  token;
  logic        strobe;
  logic        key_down;
  logic [15:0] pressed = 16'h0000;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  keypad_token_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows_n   (rows_n),
    .cols_n   (cols_n),
    .token    (token),
    .strobe   (strobe),
    .key_down (key_down)
  );

  // Membrane model: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    rows_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: printed keypad legend read as characters, digits/letters to hex.
  function automatic logic [3:0] ref_tok(input int r, input int c);
    string legend;
    int    v;
    legend = "123A456B789CF0ED";
    v = int'(legend[r*4+c]);
    if (v >= 48 && v <= 57) return 4'(v - 48);
    return 4'(v - 55);
  endfunction

  // Monitor: every strobe must match the oldest outstanding expected token.
  always @(negedge clk) begin
    if (strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe token=%0h required=no strobe", token);
      end else begin
        check("strobe_token", {28'd0, token}, {28'd0, exp_q.pop_front()});
      end
      check("key_down_at_strobe", {31'd0, key_down}, 32'd1);
    end
  end

  initial begin
    logic [3:0] one;
    logic [3:0] c0;
    int         n;
    int         r;
    int         c;
    one = 4'b0001;

    cyc(3);
    check("rst_cols_n", {28'd0, cols_n}, 32'hE);
    check("rst_token", {28'd0, token}, 32'h0);
    check("rst_strobe", {31'd0, strobe}, 32'd0);
    check("rst_key_down", {31'd0, key_down}, 32'd0);
    reset = 1'b0;

    // Idle scan: each column low for 4 cycles, in order 0..3.
    for (int k = 0; k < 20; k++) begin
      check("idle_cols_n", {28'd0, cols_n}, {28'd0, ~(one << ((k / 4) % 4))});
      cyc(1);
    end
    cyc(180);

    // '6' held 100 cycles, key_down tracks release debounce.
    exp_q.push_back(ref_tok(1, 2));
    pressed[6] = 1'b1;
    cyc(100);
    check("key_down_held", {31'd0, key_down}, 32'd1);
    pressed[6] = 1'b0;
    cyc(8);
    check("key_down_release_pending", {31'd0, key_down}, 32'd1);
    cyc(4);
    check("key_down_released", {31'd0, key_down}, 32'd0);
    cyc(20);

    // 'F' with 3-cycle bounce before settling.
    exp_q.push_back(ref_tok(3, 0));
    for (int i = 0; i < 20; i++) begin
      pressed[12] = ((i / 3) % 2) == 0;
      cyc(1);
    end
    pressed[12] = 1'b1;
    cyc(60);
    pressed[12] = 1'b0;
    cyc(30);

    // '1' held while '8' is also pressed: only '1' is reported.
    exp_q.push_back(ref_tok(0, 0));
    pressed[0] = 1'b1;
    cyc(40);
    pressed[9] = 1'b1;
    cyc(30);
    pressed[0] = 1'b0;
    pressed[9] = 1'b0;
    cyc(30);
    exp_q.push_back(ref_tok(2, 1));
    pressed[9] = 1'b1;
    cyc(50);
    pressed[9] = 1'b0;
    cyc(30);

    // Two rows in column 3: rejected, scanning continues.
    pressed[3] = 1'b1;
    pressed[7] = 1'b1;
    cyc(60);
    c0 = cols_n;
    cyc(4);
    check("scan_after_ghost", {28'd0, cols_n}, {28'd0, c0[2:0], c0[3]});
    pressed[3] = 1'b0;
    pressed[7] = 1'b0;
    cyc(20);

    // Reset while debouncing '9'; the held key is re-detected afterwards.
    n = 0;
    while (cols_n === 4'b1011 && n < 40) begin cyc(1); n++; end
    while (cols_n !== 4'b1011 && n < 40) begin cyc(1); n++; end
    check("wait_col2_in_budget", {31'd0, n < 40}, 32'd1);
    pressed[10] = 1'b1;
    cyc(8);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("midrst_cols_n", {28'd0, cols_n}, 32'hE);
    check("midrst_token", {28'd0, token}, 32'h0);
    check("midrst_strobe", {31'd0, strobe}, 32'd0);
    check("midrst_key_down", {31'd0, key_down}, 32'd0);
    exp_q.push_back(ref_tok(2, 2));
    cyc(60);
    pressed[10] = 1'b0;
    cyc(30);

    // Random single-key presses.
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      exp_q.push_back(ref_tok(r, c));
      pressed[r*4+c] = 1'b1;
      cyc(int'($urandom_range(40, 90)));
      pressed[r*4+c] = 1'b0;
      cyc(int'($urandom_range(30, 45)));
    end

    cyc(10);
    check("all_tokens_seen", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
